// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per cycle,
// with valid/ready handshakes toward the issue stage and the result consumer.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]         r_op;
  logic               r_neg;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_out_valid;

  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_res_neg;
  logic               w_div_zero;
  logic               w_ovf;
  logic               w_special;
  logic [WIDTH-1:0]   w_special_res;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic [WIDTH-1:0]   w_fix_res;

  assign in_ready   = (r_state == IDLE) & ~flush;
  assign busy       = (r_state != IDLE);
  assign out_valid  = r_out_valid;
  assign out_result = r_result;

  // Operand decode at accept: signedness, magnitudes and sign of the final result.
  assign w_a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) |
                      (funct3 == 3'b100) | (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign w_a_neg    = w_a_signed & rs1_data[WIDTH-1];
  assign w_b_neg    = w_b_signed & rs2_data[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -rs1_data : rs1_data;
  assign w_b_mag    = w_b_neg ? -rs2_data : rs2_data;
  assign w_res_neg  = (funct3[2] & funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = funct3[2] & (rs2_data == '0);
  assign w_ovf      = funct3[2] & ~funct3[0] & (rs1_data == MIN_NEG) & (rs2_data == '1);
  assign w_special  = w_div_zero | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = funct3[1] ? rs1_data : '1;
    end else begin
      w_special_res = funct3[1] ? '0 : MIN_NEG;
    end
  end

  // r_hi/r_lo hold product high/low halves, or remainder/quotient while dividing.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_quo_s  = r_neg ? -r_lo : r_lo;
  assign w_rem_s  = r_neg ? -r_hi : r_hi;

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      3'b000:                 w_fix_res = w_prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_fix_res = w_quo_s;
      default:                w_fix_res = w_rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_next = w_special ? DONE : CALC;
        CALC:    if (r_cnt == LAST_CNT) w_next = FIX;
        FIX:     w_next = DONE;
        DONE:    if (r_out_valid & out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // out_valid rises on the edge after DONE is entered and drops on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op  <= funct3;
            r_neg <= w_res_neg;
            r_cnt <= '0;
            r_hi  <= '0;
            if (funct3[2]) begin
              r_lo <= w_a_mag;
              r_b  <= w_b_mag;
            end else begin
              r_lo <= w_b_mag;
              r_b  <= w_a_mag;
            end
            if (w_special) r_result <= w_special_res;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_op[2]) begin
            if (!w_diff[WIDTH]) begin
              r_hi <= w_diff[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_hi <= w_shift[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          r_result <= w_fix_res;
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M vectors, handshake/flush/reset scenarios and
// random operations checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        outValid;
  logic        outReady;
  logic [31:0] outResult;
  logic        busy;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .flush      (flush),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .funct3     (funct3),
    .rs1_data   (rs1),
    .rs2_data   (rs2),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_result (outResult),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference result straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          sbu;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sbu = longint'({32'd0, b});
    p   = '0;
    case (f3)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * sbu; return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f3[2] && b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Wait for in_ready, present one operation for exactly the accept edge, then scramble inputs.
  task automatic issueOnly(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!inReady && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_ready_before_issue"}, 32'(inReady), 32'd1);
    funct3  = f3;
    rs1     = a;
    rs2     = b;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    funct3  = 3'($urandom_range(0, 7));
    rs1     = $urandom;
    rs2     = $urandom;
  endtask

  // Returns the number of rising edges after the accept edge until out_valid is seen.
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, output int latency);
    issueOnly(tag, f3, a, b);
    latency = 0;
    while (latency < 100) begin
      @(negedge clk);
      if (outValid) break;
      @(posedge clk);
      latency++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    int lat;
    applyStimulus(tag, f3, a, b, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_result"}, outResult, expRes);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_valid_after_take"}, 32'(outValid), 32'd0);
    checkOutput({tag, "_ready_after_take"}, 32'(inReady), 32'd1);
  endtask

  initial begin
    int          lat;
    bit          sawValid;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;

    rstN     = 1'b0;
    flush    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    funct3   = 3'd0;
    rs1      = 32'd0;
    rs2      = 32'd0;

    #12;
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_out_result", outResult, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(inReady), 32'd1);

    runOp("mul_7_neg3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    runOp("mulh_min_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    runOp("mulhu_max_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    runOp("mulhsu_neg1_2", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);
    runOp("div_neg7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    runOp("rem_neg7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    runOp("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
    runOp("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 34);
    runOp("div_by_zero", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    runOp("remu_by_zero", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    runOp("div_overflow", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    runOp("rem_overflow", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    $display("[TB] holding result in DONE with out_ready low");
    applyStimulus("hold", 3'd5, 32'd100, 32'd7, lat);
    checkOutput("hold_latency", 32'(lat), 32'd34);
    inValid = 1'b1;
    funct3  = 3'd0;
    rs1     = 32'd9;
    rs2     = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(outValid), 32'd1);
      checkOutput("hold_out_result", outResult, 32'd14);
      checkOutput("hold_in_ready", 32'(inReady), 32'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    @(negedge clk);
    checkOutput("hold_release_in_ready", 32'(inReady), 32'd1);
    checkOutput("hold_release_out_valid", 32'(outValid), 32'd0);

    $display("[TB] flush during CALC");
    issueOnly("flush", 3'd0, 32'd5, 32'd6);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("flush_idle_busy", 32'(busy), 32'd0);
    inValid = 1'b1;
    funct3  = 3'd0;
    rs1     = 32'd2;
    rs2     = 32'd2;
    #1;
    checkOutput("flush_blocks_ready", 32'(inReady), 32'd0);
    @(posedge clk);
    #1;
    flush   = 1'b0;
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("flush_no_accept", 32'(busy), 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("flush_no_result", 32'(sawValid), 32'd0);

    $display("[TB] asynchronous reset during CALC");
    issueOnly("rst", 3'd5, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy_before", 32'(busy), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_out_result", outResult, 32'd0);
    #2;
    rstN = 1'b1;
    runOp("recovery_mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 34);

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: ;
      endcase
      runOp($sformatf("rand%0d_f%0d", n, rf3), rf3, ra, rb, refModel(rf3, ra, rb),
            refLatency(rf3, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
